// File: rtl/alu_pkg.sv
// alu_pkg: ALU command encodings and the multiply-sequencer state type.
package alu_pkg;
  localparam logic [2:0] COM_A   = 3'b000;
  localparam logic [2:0] COM_B   = 3'b001;
  localparam logic [2:0] COM_AND = 3'b010;
  localparam logic [2:0] COM_OR  = 3'b011;
  localparam logic [2:0] COM_SHL = 3'b100;
  localparam logic [2:0] COM_SHR = 3'b101;
  localparam logic [2:0] COM_ADD = 3'b110;
  localparam logic [2:0] COM_SUB = 3'b111;
  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16x16 unsigned multiply sequenced over the shared ALU.
// Optional ALU_MUL_SEQ_EARLY_EXIT_EN stops once the multiplier has shifted to zero.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_com,
  input  logic [WIDTH-1:0] alu_y
);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_t state;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic last, idle_zero;
  always_comb begin
    alu_a     = state == ADD ? acc : state == SHL ? mcand : state == SHR ? mplier : '0;
    alu_b     = state == ADD ? mcand : '0;
    alu_com   = state == ADD ? COM_ADD : state == SHL ? COM_SHL : state == SHR ? COM_SHR : COM_A;
    last      = (cnt == CNT_W'(WIDTH - 1)) || (EARLY && alu_y == '0);
    idle_zero = EARLY && op_b == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
          cnt    <= '0;
          if (idle_zero) begin
            state  <= DONE;
            result <= '0;
            done   <= 1'b1;
          end else begin
            state <= op_b[0] ? ADD : SHL;
            busy  <= 1'b1;
          end
        end
        ADD: begin
          acc   <= alu_y;
          state <= SHL;
        end
        SHL: begin
          mcand <= alu_y;
          state <= SHR;
        end
        SHR: begin
          mplier <= alu_y;
          // result is loaded on the DONE-entry edge so it is valid alongside done
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= alu_y[0] ? ADD : SHL;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed self-checking bench for alu_mul_seq with a behavioural ALU.
module tb_alu_mul_seq;
  import alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, result, alu_a, alu_b, alu_y;
  logic [2:0] alu_com;
  logic busy, done;
  int n_checks = 0, n_fail = 0;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  always #5 clk = ~clk;
  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_com(alu_com), .alu_y(alu_y)
  );
  always_comb
    alu_y = alu_com == COM_A   ? alu_a :
            alu_com == COM_B   ? alu_b :
            alu_com == COM_AND ? (alu_a & alu_b) :
            alu_com == COM_OR  ? (alu_a | alu_b) :
            alu_com == COM_SHL ? (alu_a << 1) :
            alu_com == COM_SHR ? (alu_a >> 1) :
            alu_com == COM_ADD ? (alu_a + alu_b) : (alu_a - alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One multiply: cycle count is the number of clocks after the start edge until done is seen.
  task automatic mul(input string tag, input logic [15:0] a, b, er, input int ec,
                     input logic [2:0] com1, input bit pulse);
    int n;
    bit busy_ok;
    logic [15:0] prev;
    prev = result;
    @(negedge clk); op_a = a; op_b = b; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1; busy_ok = 1'b1;
    chk({tag, " first com"}, 32'(alu_com), 32'(com1));
    while (!done && n < 200) begin
      if (!busy || result !== prev) busy_ok = 1'b0;
      if (n == 3) begin op_a = 16'hDEAD; op_b = 16'hBEEF; end
      if (pulse && n == 5) begin start = 1'b1; op_a = 16'd2; op_b = 16'd3; end
      if (n == 6) start = 1'b0;
      @(negedge clk); n++;
    end
    chk({tag, " cycles"}, 32'(n), 32'(ec));
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " busy/hold"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " result held"}, 32'(result), 32'(er));
  endtask

  initial begin
    int n, pulses;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset alu", {13'd0, alu_com, alu_a}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    mul("basic 3*5", 16'd3, 16'd5, 16'd15, EARLY ? 9 : 35, COM_ADD, 1'b0);
    mul("wrap", 16'hFFFF, 16'hFFFF, 16'h0001, 49, COM_ADD, 1'b0);
    mul("zero", 16'h1234, 16'h0000, 16'h0000, EARLY ? 1 : 33, EARLY ? COM_A : COM_SHL, 1'b0);
    mul("ignored start 7*9", 16'd7, 16'd9, 16'd63, EARLY ? 11 : 35, COM_ADD, 1'b0);
    mul("pulse while busy", 16'd7, 16'd9, 16'd63, EARLY ? 11 : 35, COM_ADD, 1'b1);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    chk("no second done", 32'(pulses), 32'd0);
    @(negedge clk); op_a = 16'hFFFF; op_b = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset result", 32'(result), 32'd0);
    chk("midreset alu_com", 32'(alu_com), 32'(COM_A));
    @(negedge clk); rst_n = 1'b1;
    mul("after reset 2*2", 16'd2, 16'd2, 16'd4, EARLY ? 6 : 34, COM_SHL, 1'b0);
    // start held high: a new multiply is accepted in the IDLE cycle after DONE
    @(negedge clk); op_a = 16'd3; op_b = 16'd5; start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    chk("b2b first cycles", 32'(n), EARLY ? 32'd9 : 32'd35);
    chk("b2b first result", 32'(result), 32'd15);
    op_a = 16'd2; op_b = 16'd2;
    @(negedge clk);
    chk("b2b idle done", 32'(done), 32'd0);
    chk("b2b idle hold", 32'(result), 32'd15);
    n = 0; pulses = 0;
    do begin
      @(negedge clk); n++;
      if (!done && result !== 16'd15) pulses++;
    end while (!done && n < 200);
    start = 1'b0;
    chk("b2b second cycles", 32'(n), EARLY ? 32'd6 : 32'd34);
    chk("b2b second result", 32'(result), 32'd4);
    chk("b2b hold until done", 32'(pulses), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
